// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard receiver: synchronise, glitch-filter, frame, decode to Hack key codes.
// Optional PS2_SHIFT_EN adds shift tracking (lower-case letters, shifted digit symbols).
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       frame_strobe,
    output logic       frame_error
);
    // state | meaning
    // IDLE   | waiting for a start bit (sampled 0)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the odd-parity bit
    // STOP   | checking the stop bit, completing the byte
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    typedef enum logic [1:0] {K_NONE, K_PLAIN, K_LET, K_DIG} kind_t;

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES);

    logic [1:0]     clk_sync, data_sync;
    logic           clk_s, data_s;
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall, timeout, sample;
    logic [TCW-1:0] tmo_cnt;
    state_t         state_q, state_d;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic           ext, brk;
    logic [7:0]     code_raw, map_code;
    kind_t          kind;
    logic           map_hit;
`ifdef PS2_SHIFT_EN
    logic           shift_held;
    logic [8:0]     held_scan;
    logic           is_shift;
`endif

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample;
    // the falling flip doubles as the data sampling strobe.
    assign fall = clk_filt && !clk_s && (filt_cnt == FILT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FCW'(1);
        end
    end

    assign timeout = (state_q != IDLE) && (tmo_cnt == TMO_LAST);
    assign sample  = fall && !timeout;

    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE || fall) tmo_cnt <= '0;
        else if (tmo_cnt != TMO_LAST)       tmo_cnt <= tmo_cnt + TCW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (sample) begin
            case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_cnt == 4'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        code_raw = 8'd0;
        kind     = K_NONE;
        case ({ext, shreg})
            9'h01C: begin code_raw = 8'd65;  kind = K_LET; end
            9'h032: begin code_raw = 8'd66;  kind = K_LET; end
            9'h021: begin code_raw = 8'd67;  kind = K_LET; end
            9'h023: begin code_raw = 8'd68;  kind = K_LET; end
            9'h024: begin code_raw = 8'd69;  kind = K_LET; end
            9'h02B: begin code_raw = 8'd70;  kind = K_LET; end
            9'h034: begin code_raw = 8'd71;  kind = K_LET; end
            9'h033: begin code_raw = 8'd72;  kind = K_LET; end
            9'h043: begin code_raw = 8'd73;  kind = K_LET; end
            9'h03B: begin code_raw = 8'd74;  kind = K_LET; end
            9'h042: begin code_raw = 8'd75;  kind = K_LET; end
            9'h04B: begin code_raw = 8'd76;  kind = K_LET; end
            9'h03A: begin code_raw = 8'd77;  kind = K_LET; end
            9'h031: begin code_raw = 8'd78;  kind = K_LET; end
            9'h044: begin code_raw = 8'd79;  kind = K_LET; end
            9'h04D: begin code_raw = 8'd80;  kind = K_LET; end
            9'h015: begin code_raw = 8'd81;  kind = K_LET; end
            9'h02D: begin code_raw = 8'd82;  kind = K_LET; end
            9'h01B: begin code_raw = 8'd83;  kind = K_LET; end
            9'h02C: begin code_raw = 8'd84;  kind = K_LET; end
            9'h03C: begin code_raw = 8'd85;  kind = K_LET; end
            9'h02A: begin code_raw = 8'd86;  kind = K_LET; end
            9'h01D: begin code_raw = 8'd87;  kind = K_LET; end
            9'h022: begin code_raw = 8'd88;  kind = K_LET; end
            9'h035: begin code_raw = 8'd89;  kind = K_LET; end
            9'h01A: begin code_raw = 8'd90;  kind = K_LET; end
            9'h016: begin code_raw = 8'd49;  kind = K_DIG; end
            9'h01E: begin code_raw = 8'd50;  kind = K_DIG; end
            9'h026: begin code_raw = 8'd51;  kind = K_DIG; end
            9'h025: begin code_raw = 8'd52;  kind = K_DIG; end
            9'h02E: begin code_raw = 8'd53;  kind = K_DIG; end
            9'h036: begin code_raw = 8'd54;  kind = K_DIG; end
            9'h03D: begin code_raw = 8'd55;  kind = K_DIG; end
            9'h03E: begin code_raw = 8'd56;  kind = K_DIG; end
            9'h046: begin code_raw = 8'd57;  kind = K_DIG; end
            9'h045: begin code_raw = 8'd48;  kind = K_DIG; end
            9'h029: begin code_raw = 8'd32;  kind = K_PLAIN; end
            9'h05A: begin code_raw = 8'd128; kind = K_PLAIN; end
            9'h066: begin code_raw = 8'd129; kind = K_PLAIN; end
            9'h076: begin code_raw = 8'd140; kind = K_PLAIN; end
            9'h005: begin code_raw = 8'd141; kind = K_PLAIN; end
            9'h006: begin code_raw = 8'd142; kind = K_PLAIN; end
            9'h004: begin code_raw = 8'd143; kind = K_PLAIN; end
            9'h00C: begin code_raw = 8'd144; kind = K_PLAIN; end
            9'h003: begin code_raw = 8'd145; kind = K_PLAIN; end
            9'h00B: begin code_raw = 8'd146; kind = K_PLAIN; end
            9'h083: begin code_raw = 8'd147; kind = K_PLAIN; end
            9'h00A: begin code_raw = 8'd148; kind = K_PLAIN; end
            9'h001: begin code_raw = 8'd149; kind = K_PLAIN; end
            9'h009: begin code_raw = 8'd150; kind = K_PLAIN; end
            9'h078: begin code_raw = 8'd151; kind = K_PLAIN; end
            9'h007: begin code_raw = 8'd152; kind = K_PLAIN; end
            9'h16B: begin code_raw = 8'd130; kind = K_PLAIN; end
            9'h175: begin code_raw = 8'd131; kind = K_PLAIN; end
            9'h174: begin code_raw = 8'd132; kind = K_PLAIN; end
            9'h172: begin code_raw = 8'd133; kind = K_PLAIN; end
            9'h16C: begin code_raw = 8'd134; kind = K_PLAIN; end
            9'h169: begin code_raw = 8'd135; kind = K_PLAIN; end
            9'h17D: begin code_raw = 8'd136; kind = K_PLAIN; end
            9'h17A: begin code_raw = 8'd137; kind = K_PLAIN; end
            9'h170: begin code_raw = 8'd138; kind = K_PLAIN; end
            9'h171: begin code_raw = 8'd139; kind = K_PLAIN; end
            9'h15A: begin code_raw = 8'd128; kind = K_PLAIN; end
            default: begin code_raw = 8'd0; kind = K_NONE; end
        endcase
    end

    assign map_hit = (kind != K_NONE);

    always_comb begin
        map_code = code_raw;
`ifdef PS2_SHIFT_EN
        if (kind == K_LET && !shift_held) begin
            map_code = code_raw + 8'd32;
        end else if (kind == K_DIG && shift_held) begin
            case (code_raw)
                8'd49:   map_code = 8'd33;
                8'd50:   map_code = 8'd64;
                8'd51:   map_code = 8'd35;
                8'd52:   map_code = 8'd36;
                8'd53:   map_code = 8'd37;
                8'd54:   map_code = 8'd94;
                8'd55:   map_code = 8'd38;
                8'd56:   map_code = 8'd42;
                8'd57:   map_code = 8'd40;
                default: map_code = 8'd41;
            endcase
        end
`endif
    end

`ifdef PS2_SHIFT_EN
    assign is_shift = !ext && (shreg == 8'h12 || shreg == 8'h59);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= 4'd0;
            shreg        <= 8'd0;
            par_bit      <= 1'b0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            keycode      <= 8'd0;
            frame_strobe <= 1'b0;
            frame_error  <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_held   <= 1'b0;
            held_scan    <= 9'd0;
`endif
        end else begin
            frame_strobe <= 1'b0;
            frame_error  <= 1'b0;
            if (sample) begin
                case (state_q)
                    IDLE:   bit_cnt <= 4'd0;
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    PARITY: par_bit <= data_s;
                    STOP: begin
                        if (data_s && (^{shreg, par_bit})) begin
                            frame_strobe <= 1'b1;
                            if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                ext <= 1'b0;
                                brk <= 1'b0;
`ifdef PS2_SHIFT_EN
                                // Breaks match on the scan code seen at make, not the shifted code.
                                if (is_shift) begin
                                    shift_held <= !brk;
                                end else if (map_hit) begin
                                    if (!brk) begin
                                        keycode   <= map_code;
                                        held_scan <= {ext, shreg};
                                    end else if (held_scan == {ext, shreg}) begin
                                        keycode <= 8'd0;
                                    end
                                end
`else
                                if (map_hit) begin
                                    if (!brk)                     keycode <= map_code;
                                    else if (map_code == keycode) keycode <= 8'd0;
                                end
`endif
                            end
                        end else begin
                            frame_error <= 1'b1;
                            ext         <= 1'b0;
                            brk         <= 1'b0;
                        end
                    end
                    default: bit_cnt <= 4'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: bit-banged PS/2 frames with hand-computed key codes.
module tb_ps2_keyboard_decoder;
    localparam int FL   = 4;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       frame_strobe, frame_error;

    int cyc = 0;
    int fall_cyc = 0;
    int strobe_cnt = 0, err_cnt = 0, overlap = 0, dbl = 0;
    int strobe_cyc = 0, strobe_key = 0;
    logic prev_pulse = 1'b0;
    int n_checks = 0, n_fail = 0;
    int s0, e0;

    ps2_keyboard_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .frame_strobe(frame_strobe), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            strobe_cyc <= cyc;
            strobe_key <= int'(keycode);
        end
        if (frame_error) err_cnt <= err_cnt + 1;
        if (frame_strobe && frame_error) overlap <= overlap + 1;
        if ((frame_strobe || frame_error) && prev_pulse) dbl <= dbl + 1;
        prev_pulse <= frame_strobe || frame_error;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        wait_cyc(1);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        logic par;
        par = ~(^b) ^ bad_parity;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
        wait_cyc(HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        check("reset_keycode", int'(keycode), 0);
        check("reset_strobe", int'(frame_strobe), 0);
        check("reset_error", int'(frame_error), 0);

        // single key
        s0 = strobe_cnt;
        send(8'h1C);
        check("single_make", int'(keycode), 65);
        check("strobe_latency", strobe_cyc - fall_cyc, FL + 2);
        check("key_at_strobe", strobe_key, 65);
        send(8'hF0);
        check("break_prefix_hold", int'(keycode), 65);
        send(8'h1C);
        check("single_break", int'(keycode), 0);
        check("single_strobes", strobe_cnt - s0, 3);

        // extended key
        send(8'hE0); send(8'h75);
        check("ext_make", int'(keycode), 131);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break", int'(keycode), 0);
        s0 = strobe_cnt;
        send(8'h74);
        check("plain_74_unmapped", int'(keycode), 0);
        check("unmapped_strobe", strobe_cnt - s0, 1);

        // parity error, and it drops a pending E0
        s0 = strobe_cnt; e0 = err_cnt;
        send(8'hE0);
        send_frame(8'h1C, 1'b1);
        check("parity_err_pulse", err_cnt - e0, 1);
        check("parity_no_strobe", strobe_cnt - s0, 1);
        check("parity_keycode", int'(keycode), 0);
        send(8'h75);
        check("prefix_cleared_by_err", int'(keycode), 0);
        send(8'h29);
        check("space_after_err", int'(keycode), 32);
        send(8'hF0); send(8'h29);
        check("space_break", int'(keycode), 0);

        // timeout of a partial frame
        e0 = err_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_cyc(TMO + 1);
        send(8'h5A);
        check("timeout_enter", int'(keycode), 128);
        check("timeout_no_error", err_cnt - e0, 0);
        send(8'hF0); send(8'h5A);
        check("enter_break", int'(keycode), 0);

        // rollover
        send(8'h1C);
        send(8'h32);
        check("rollover_make_b", int'(keycode), 66);
        send(8'hF0); send(8'h1C);
        check("rollover_break_a", int'(keycode), 66);
        send(8'hF0); send(8'h32);
        check("rollover_break_b", int'(keycode), 0);

        // function key, unmapped AA, escape
        send(8'h83);
        check("f7_make", int'(keycode), 147);
        send(8'h76);
        check("esc_make", int'(keycode), 140);
        send(8'hAA);
        check("aa_unmapped", int'(keycode), 140);
        send(8'hF0); send(8'h83);
        check("f7_break_other", int'(keycode), 140);

        // reset mid-frame discards keycode, partial frame and pending E0
        send(8'hE0);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(HALF);
        check("midreset_keycode", int'(keycode), 0);
        send(8'h75);
        check("midreset_ext_cleared", int'(keycode), 0);
        send(8'h1C);
        check("after_reset_make", int'(keycode), 65);
        send(8'hF0); send(8'h1C);
        check("after_reset_break", int'(keycode), 0);

        // shift sequences
`ifdef PS2_SHIFT_EN
        send(8'h1C);
        check("shift_none_letter", int'(keycode), 97);
        send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h1C);
        check("shift_letter", int'(keycode), 65);
        send(8'hF0); send(8'h1C);
        check("shift_letter_break", int'(keycode), 0);
        send(8'h16);
        check("shift_digit", int'(keycode), 33);
        send(8'hF0); send(8'h12);
        check("shift_release_keeps", int'(keycode), 33);
        send(8'hF0); send(8'h16);
        check("shift_digit_break", int'(keycode), 0);
`else
        send(8'h1C);
        check("noshift_letter", int'(keycode), 65);
        send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h1C);
        check("noshift_12_letter", int'(keycode), 65);
        send(8'hF0); send(8'h1C);
        check("noshift_letter_break", int'(keycode), 0);
        send(8'h16);
        check("noshift_digit", int'(keycode), 49);
        send(8'hF0); send(8'h12);
        check("noshift_12_break", int'(keycode), 49);
        send(8'hF0); send(8'h16);
        check("noshift_digit_break", int'(keycode), 0);
`endif

        wait_cyc(2);
        check("pulse_overlap", overlap, 0);
        check("pulse_width", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
